// File: rtl/repne_cmps_sequencer.sv
// ---------------------------------------------------------------------------
// repne_cmps_sequencer
//
// Micro-sequencer for REPNE CMPS. Each iteration issues an ESI (FIRST) uop and
// an EDI (SECOND) uop, then waits for the compare result from writeback. After
// each result it decrements ECX and stops when ECX reaches zero or ZF is set.
// Decode is stalled (BUSY) while an iteration sequence is active.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   START               decode presents REPNE CMPS (sampled only in IDLE)
//   ECX_INIT            initial ECX count
//   MEM_SIZE            00 byte, 01 word, 10/11 dword
//   EFLAGS_DF           direction flag captured at START
//   STALL               downstream stall, holds the presented uop
//   FLUSH               aborts any active sequence
//   CMP_DONE_V, CMP_ZF  compare result from writeback (used only in WAIT)
//   UOP_V               a CMPS uop is presented
//   CS_IS_CMPS_FIRST    presented uop is the ESI uop
//   CS_IS_CMPS_SECOND   presented uop is the EDI uop
//   CS_REPNE_STEADY     iteration 2 or later (AG uses saved pointers + step)
//   STEP_OUT            signed pointer step (+/-1, 2 or 4)
//   ECX_WR, ECX_OUT     registered one-cycle ECX writeback
//   BUSY                sequence active (FIRST, SECOND, WAIT)
//   DONE                one-cycle completion pulse (FIN)
//   dbg_state           current FSM state for observation
//
// Uop handshake: a uop is offered while UOP_V=1 and is accepted on a clock
// edge where STALL=0 (STALL acts as the inverted ready). While STALL=1 the
// uop and all its flags stay unchanged.
// ---------------------------------------------------------------------------
module repne_cmps_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [CNT_W-1:0] ECX_INIT,
    input  logic [1:0]       MEM_SIZE,
    input  logic             EFLAGS_DF,
    input  logic             STALL,
    input  logic             FLUSH,
    input  logic             CMP_DONE_V,
    input  logic             CMP_ZF,
    output logic             UOP_V,
    output logic             CS_IS_CMPS_FIRST,
    output logic             CS_IS_CMPS_SECOND,
    output logic             CS_REPNE_STEADY,
    output logic [31:0]      STEP_OUT,
    output logic             ECX_WR,
    output logic [CNT_W-1:0] ECX_OUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FIRST  = 3'd1,
        S_SECOND = 3'd2,
        S_WAIT   = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] ecx;
    logic [CNT_W-1:0] ecx_dec;
    logic             steady;
    logic             last_iter;
    logic [31:0]      step_mag;
    logic [31:0]      step_sel;

    assign ecx_dec   = ecx - CNT_W'(1);
    // Iteration ends the loop when the decremented count hits zero or the
    // compare found equality.
    assign last_iter = (ecx_dec == '0) || CMP_ZF;

    always_comb begin
        step_mag = 32'd4;
        case (MEM_SIZE)
            2'b00:   step_mag = 32'd1;
            2'b01:   step_mag = 32'd2;
            default: step_mag = 32'd4;
        endcase
        step_sel = EFLAGS_DF ? (32'd0 - step_mag) : step_mag;
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (FLUSH && (state != S_IDLE)) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state_next = (ECX_INIT == '0) ? S_FIN : S_FIRST;
                    end
                end
                S_FIRST: begin
                    if (!STALL) state_next = S_SECOND;
                end
                S_SECOND: begin
                    if (!STALL) state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (CMP_DONE_V) begin
                        state_next = last_iter ? S_FIN : S_FIRST;
                    end
                end
                S_FIN:   state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        UOP_V             = (state == S_FIRST) || (state == S_SECOND);
        CS_IS_CMPS_FIRST  = (state == S_FIRST);
        CS_IS_CMPS_SECOND = (state == S_SECOND);
        CS_REPNE_STEADY   = steady && ((state == S_FIRST) || (state == S_SECOND));
        BUSY              = (state == S_FIRST) || (state == S_SECOND) || (state == S_WAIT);
        DONE              = (state == S_FIN);
    end

    assign dbg_state = state;

    // Datapath: latched count, pointer step, steady flag, ECX writeback
    always_ff @(posedge CLK) begin
        if (RST) begin
            ecx      <= '0;
            steady   <= 1'b0;
            STEP_OUT <= '0;
            ECX_WR   <= 1'b0;
            ECX_OUT  <= '0;
        end else begin
            ECX_WR <= 1'b0;
            if (FLUSH && (state != S_IDLE)) begin
                // Abort: any compare result arriving now is dropped.
                steady <= 1'b0;
            end else if ((state == S_IDLE) && START) begin
                // Step is captured on every START, even a zero-count one.
                STEP_OUT <= step_sel;
                if (ECX_INIT != '0) begin
                    ecx    <= ECX_INIT;
                    steady <= 1'b0;
                end
            end else if ((state == S_WAIT) && CMP_DONE_V) begin
                ecx     <= ecx_dec;
                ECX_WR  <= 1'b1;
                ECX_OUT <= ecx_dec;
                if (!last_iter) steady <= 1'b1;
            end
        end
    end

endmodule
